bcd_alu: RTL and testbench
==========================

Name: bcd_alu

Overview:
- Four-digit packed-BCD arithmetic unit for the calculator datapath.
- Takes two 16-bit BCD operands and a 4-bit operation code.
- Computes add, subtract, multiply or integer divide, and registers the BCD result on the next rising clock edge.
- Sits between the keypad/operand registers and the display driver.

Parameters:
- DIGITS, 4, number of BCD digits per operand and result (fixed at 4; widths below derive from it).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- num1  input  16  operand A, packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- num2  input  16  operand B, packed BCD, same layout as num1.
- op  input  4  operation select.
- res  output  16  registered packed-BCD result.
- err  output  1  registered error flag for the operation that produced the current res.

Behaviour:
- Reset: when rst=1 at a rising edge, res <= 16'h0000 and err <= 0. rst has priority over everything else.
- Operation codes:
  - 4'b1100: add.
  - 4'b1101: subtract (num1 - num2).
  - 4'b1110: multiply.
  - 4'b1111: integer divide (num1 / num2, quotient truncated toward zero, remainder discarded).
  - 4'b0000-4'b1011: no-op. res and err hold their previous values.
- Latency: the result is a combinational function of the current num1, num2 and op. It is captured into res/err at the next rising edge, so latency is 1 cycle. A new operation may be presented every cycle, with no handshake.
- Operands are unsigned decimal values 0..9999. Arithmetic is done on the decimal values. A valid internal route is BCD to binary, compute, then binary to BCD (double-dabble).
- Invalid BCD: if any nibble of num1 or num2 is greater than 9 and op is a valid operation, then res <= 0 and err <= 1.
- Add: res = (A+B) mod 10000. err = 1 if A+B > 9999, else 0.
- Subtract:
  - If A >= B: res = A-B, err = 0.
  - If A < B: res = (A-B+10000) mod 10000 (ten's complement), err = 1.
- Multiply: res = (A*B) mod 10000. err = 1 if A*B > 9999, else 0.
- Divide:
  - If B = 0: res = 0, err = 1.
  - Otherwise: res = floor(A/B), err = 0.
- Every valid nibble of res is always a BCD digit 0..9.
- Inputs changing mid-cycle have no effect until the next rising edge. There are no internal state machines and no multi-cycle operations.

Test Plan:
- Divide:
  - num1=16'h0014, num2=16'h0007, op=1111 -> res=16'h0002, err=0.
  - num1=16'h0016, num2=16'h0007, op=1111 -> res=16'h0002, err=0 (truncation).
- Multiply:
  - num1=16'h0010, num2=16'h0010, op=1110 -> res=16'h0100, err=0.
  - num1=16'h0002, num2=16'h1000, op=1110 -> res=16'h2000, err=0.
  - num1=16'h0200, num2=16'h0050, op=1110 -> res=16'h0000, err=1 (overflow).
- Subtract:
  - num1=16'h9999, num2=16'h9999, op=1101 -> res=16'h0000, err=0.
  - num1=16'h9999, num2=16'h8999, op=1101 -> res=16'h1000, err=0.
  - num1=16'h0003, num2=16'h0005, op=1101 -> res=16'h9998, err=1.
- Add:
  - num1=16'h5000, num2=16'h4000, op=1100 -> res=16'h9000, err=0.
  - num1=16'h9999, num2=16'h0001, op=1100 -> res=16'h0000, err=1.
- Errors and holds:
  - num1=16'h0008, num2=16'h0000, op=1111 -> res=16'h0000, err=1 (divide by zero).
  - num1=16'h00A1, op=1100 -> res=16'h0000, err=1 (invalid BCD).
  - After any result, set op=0000 -> res and err hold.
- Reset:
  - Assert rst for one cycle mid-sequence -> res=16'h0000, err=0 at that edge.
  - Result reappears one cycle after rst deasserts.
  - Result always appears exactly one edge after inputs change.

Source files
------------

// File: rtl/bcd_alu.sv
// Four-digit packed-BCD arithmetic unit: add, subtract, multiply, divide.
// Operands are converted to binary, computed, and converted back to BCD
// with double-dabble; the result and error flag register one edge later.
module bcd_alu #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] num1,
    input  logic [4*DIGITS-1:0] num2,
    input  logic [3:0]          op,
    output logic [4*DIGITS-1:0] res,
    output logic                err
);

    localparam logic [3:0] OP_ADD = 4'b1100;
    localparam logic [3:0] OP_SUB = 4'b1101;
    localparam logic [3:0] OP_MUL = 4'b1110;
    localparam logic [3:0] OP_DIV = 4'b1111;

    // Packed BCD (0..9999) to binary; nibbles above 9 are screened out separately.
    function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
        return 14'(bcd[15:12]) * 14'd1000
             + 14'(bcd[11:8])  * 14'd100
             + 14'(bcd[7:4])   * 14'd10
             + 14'(bcd[3:0]);
    endfunction

    // Binary (0..9999) to packed BCD via shift-and-add-3.
    function automatic logic [15:0] bin_to_bcd(input logic [13:0] bin);
        logic [15:0] bcd;
        bcd = 16'h0000;
        for (int i = 13; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (bcd[d*4 +: 4] >= 4'd5)
                    bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            end
            bcd = {bcd[14:0], bin[i]};
        end
        return bcd;
    endfunction

    // True when any nibble of the operand is not a decimal digit.
    function automatic logic has_bad_digit(input logic [15:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < 4; d++) begin
            if (bcd[d*4 +: 4] > 4'd9)
                bad = 1'b1;
        end
        return bad;
    endfunction

    logic [13:0] a_bin;
    logic [13:0] b_bin;
    logic [14:0] sum;
    logic [27:0] prod;
    logic [13:0] bin_res;
    logic        op_valid;
    logic        bad_input;
    logic [15:0] next_res;
    logic        next_err;

    assign a_bin     = bcd_to_bin(num1);
    assign b_bin     = bcd_to_bin(num2);
    assign sum       = 15'(a_bin) + 15'(b_bin);
    assign prod      = 28'(a_bin) * 28'(b_bin);
    assign op_valid  = (op[3:2] == 2'b11);
    assign bad_input = has_bad_digit(num1) || has_bad_digit(num2);

    // Select the binary result and error flag for the requested operation.
    always_comb begin
        bin_res  = 14'd0;
        next_err = 1'b0;
        unique case (op)
            OP_ADD: begin
                if (sum > 15'd9999) begin
                    bin_res  = 14'(sum - 15'd10000);
                    next_err = 1'b1;
                end else begin
                    bin_res  = 14'(sum);
                end
            end
            OP_SUB: begin
                if (a_bin >= b_bin) begin
                    bin_res  = a_bin - b_bin;
                end else begin
                    // Ten's complement wrap: A - B + 10000.
                    bin_res  = 14'(15'(a_bin) + 15'd10000 - 15'(b_bin));
                    next_err = 1'b1;
                end
            end
            OP_MUL: begin
                bin_res  = 14'(prod % 28'd10000);
                next_err = (prod > 28'd9999);
            end
            OP_DIV: begin
                if (b_bin == 14'd0) begin
                    next_err = 1'b1;
                end else begin
                    bin_res  = a_bin / b_bin;
                end
            end
            default: begin
                bin_res  = 14'd0;
                next_err = 1'b0;
            end
        endcase
        if (bad_input) begin
            bin_res  = 14'd0;
            next_err = 1'b1;
        end
    end

    assign next_res = bin_to_bcd(bin_res);

    // Capture the result on valid operations; no-op codes hold res and err.
    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
            err <= 1'b0;
        end else if (op_valid) begin
            res <= next_res;
            err <= next_err;
        end
    end

endmodule

// File: tb/tb_bcd_alu.sv
// Directed-vector bench for bcd_alu with hand-computed expected results.
module tb_bcd_alu;

    logic        clk;
    logic        rst;
    logic [15:0] num1;
    logic [15:0] num2;
    logic [3:0]  op;
    logic [15:0] res;
    logic        err;

    int total_cnt;
    int pass_cnt;

    bcd_alu #(.DIGITS(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .num1 (num1),
        .num2 (num2),
        .op   (op),
        .res  (res),
        .err  (err)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            pass_cnt++;
    endtask

    // Present one operation, wait one edge, compare res and err.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] o, input logic [15:0] exp_res, input logic exp_err);
        num1 = a;
        num2 = b;
        op   = o;
        @(posedge clk);
        #1;
        check({tag, ".res"}, res, exp_res);
        check({tag, ".err"}, {15'd0, err}, {15'd0, exp_err});
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst  = 1'b1;
        num1 = 16'h1234;
        num2 = 16'h4321;
        op   = 4'b1100;
        repeat (2) @(posedge clk);
        #1;
        check("reset.res", res, 16'h0000);
        check("reset.err", {15'd0, err}, 16'd0);
        rst = 1'b0;

        run_op("div_14_7",     16'h0014, 16'h0007, 4'b1111, 16'h0002, 1'b0);
        run_op("div_16_7",     16'h0016, 16'h0007, 4'b1111, 16'h0002, 1'b0);
        run_op("div_9999_3",   16'h9999, 16'h0003, 4'b1111, 16'h3333, 1'b0);
        run_op("div_0_5",      16'h0000, 16'h0005, 4'b1111, 16'h0000, 1'b0);
        run_op("mul_10_10",    16'h0010, 16'h0010, 4'b1110, 16'h0100, 1'b0);
        run_op("mul_2_1000",   16'h0002, 16'h1000, 4'b1110, 16'h2000, 1'b0);
        run_op("mul_99_101",   16'h0099, 16'h0101, 4'b1110, 16'h9999, 1'b0);
        run_op("mul_ovf",      16'h0200, 16'h0050, 4'b1110, 16'h0000, 1'b1);
        run_op("mul_ovf_wrap", 16'h0123, 16'h0100, 4'b1110, 16'h2300, 1'b1);
        run_op("sub_eq",       16'h9999, 16'h9999, 4'b1101, 16'h0000, 1'b0);
        run_op("sub_1000",     16'h9999, 16'h8999, 4'b1101, 16'h1000, 1'b0);
        run_op("sub_borrow",   16'h1000, 16'h0001, 4'b1101, 16'h0999, 1'b0);
        run_op("sub_neg",      16'h0003, 16'h0005, 4'b1101, 16'h9998, 1'b1);
        run_op("add_9000",     16'h5000, 16'h4000, 4'b1100, 16'h9000, 1'b0);
        run_op("add_5555",     16'h1234, 16'h4321, 4'b1100, 16'h5555, 1'b0);
        run_op("add_carry",    16'h0999, 16'h0001, 4'b1100, 16'h1000, 1'b0);
        run_op("add_ovf",      16'h9999, 16'h0001, 4'b1100, 16'h0000, 1'b1);
        run_op("add_ovf_wrap", 16'h9999, 16'h0002, 4'b1100, 16'h0001, 1'b1);

        // Hold on no-op after a normal result.
        run_op("set_7777",     16'h7000, 16'h0777, 4'b1100, 16'h7777, 1'b0);
        run_op("hold_op0",     16'h0001, 16'h0001, 4'b0000, 16'h7777, 1'b0);
        run_op("hold_op1011",  16'h0000, 16'h0000, 4'b1011, 16'h7777, 1'b0);

        run_op("div_by_zero",  16'h0008, 16'h0000, 4'b1111, 16'h0000, 1'b1);
        run_op("hold_err",     16'h0001, 16'h0002, 4'b0111, 16'h0000, 1'b1);
        run_op("bad_num1",     16'h00A1, 16'h0000, 4'b1100, 16'h0000, 1'b1);
        run_op("set_0042",     16'h0040, 16'h0002, 4'b1100, 16'h0042, 1'b0);
        run_op("bad_num2",     16'h0500, 16'h0F00, 4'b1101, 16'h0000, 1'b1);
        run_op("set_0042b",    16'h0040, 16'h0002, 4'b1100, 16'h0042, 1'b0);
        run_op("bad_noop",     16'hFFFF, 16'h0000, 4'b0101, 16'h0042, 1'b0);

        // Inputs changed after an edge must not show until the next edge.
        num1 = 16'h0300;
        num2 = 16'h0003;
        op   = 4'b1110;
        #2;
        check("latency_before.res", res, 16'h0042);
        @(posedge clk);
        #1;
        check("latency_after.res", res, 16'h0900);

        // Mid-sequence reset with a valid operation still presented.
        run_op("pre_rst",      16'h2000, 16'h9000, 4'b1100, 16'h1000, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst.res", res, 16'h0000);
        check("mid_rst.err", {15'd0, err}, 16'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst.res", res, 16'h1000);
        check("post_rst.err", {15'd0, err}, 16'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
